// File: rtl/qtree_result_fifo.sv
// Result FIFO at the tail of the quadtree lookup pipeline: captures completed lookups, serves them via valid/ready.
// Optional statistics counters (hit/miss/drop) are built when QTREE_RESULT_STATS_EN is defined.
module qtree_result_fifo #(
  parameter int A_WIDTH    = 6,
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          lookup_done_i,
  input  logic                          lookup_match_i,
  input  logic [A_WIDTH-1:0]            lookup_addr_i,
  input  logic [D_WIDTH-1:0]            lookup_data_i,
  input  logic                          clr_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          res_match_o,
  output logic [A_WIDTH-1:0]            res_addr_o,
  output logic [D_WIDTH-1:0]            res_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [CNT_WIDTH-1:0]          hit_cnt_o,
  output logic [CNT_WIDTH-1:0]          miss_cnt_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef struct packed {
    logic               match;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
  } res_t;

  res_t        r_mem [FIFO_DEPTH];
  logic [PW:0] r_wr_ptr, r_rd_ptr;
  logic        r_overflow;
  logic        w_empty, w_full, w_push, w_pop, w_drop;
  res_t        w_wr_ent, w_head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop   = !w_empty && res_ready_i;
  assign w_push  = lookup_done_i && (!w_full || w_pop);
  assign w_drop  = lookup_done_i && w_full && !w_pop;

  assign w_wr_ent = '{match: lookup_match_i,
                      addr:  lookup_match_i ? lookup_addr_i : '0,
                      data:  lookup_data_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage is deliberately unreset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= w_wr_ent;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_overflow <= 1'b0;
    else if (clr_i)  r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign w_head       = r_mem[r_rd_ptr[PW-1:0]];
  assign res_valid_o  = !w_empty;
  assign res_match_o  = w_head.match;
  assign res_addr_o   = w_head.addr;
  assign res_data_o   = w_head.data;
  assign fifo_level_o = r_wr_ptr - r_rd_ptr;
  assign overflow_o   = r_overflow;

`ifdef QTREE_RESULT_STATS_EN
  logic [CNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt, r_drop_cnt;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Counters saturate rather than wrap so a long run never reads as a small count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (clr_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && lookup_match_i && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + CNT_ONE;
      if (w_push && !lookup_match_i && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_ONE;
      if (w_drop && (r_drop_cnt != '1))                    r_drop_cnt <= r_drop_cnt + CNT_ONE;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign drop_cnt_o = r_drop_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_qtree_result_fifo.sv
// Self-checking bench for qtree_result_fifo: queue-based reference model checked every cycle plus directed checks.
module tb_qtree_result_fifo;
  localparam int A_WIDTH = 6, D_WIDTH = 16, FIFO_DEPTH = 8, CNT_WIDTH = 16;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic lookup_done_i = 1'b0, lookup_match_i = 1'b0, clr_i = 1'b0, res_ready_i = 1'b0;
  logic [A_WIDTH-1:0] lookup_addr_i = '0;
  logic [D_WIDTH-1:0] lookup_data_i = '0;
  logic res_valid_o, res_match_o, overflow_o;
  logic [A_WIDTH-1:0] res_addr_o;
  logic [D_WIDTH-1:0] res_data_o;
  logic [LW-1:0] fifo_level_o;
  logic [CNT_WIDTH-1:0] hit_cnt_o, miss_cnt_o, drop_cnt_o;

  qtree_result_fifo #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lookup_done_i(lookup_done_i), .lookup_match_i(lookup_match_i),
    .lookup_addr_i(lookup_addr_i), .lookup_data_i(lookup_data_i), .clr_i(clr_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_match_o(res_match_o),
    .res_addr_o(res_addr_o), .res_data_o(res_data_o), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .drop_cnt_o(drop_cnt_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic               m;
    logic [A_WIDTH-1:0] a;
    logic [D_WIDTH-1:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;
  logic [CNT_WIDTH-1:0] m_hit = '0, m_miss = '0, m_drop = '0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CNT_WIDTH-1:0] exp_cnt(input logic [CNT_WIDTH-1:0] v);
`ifdef QTREE_RESULT_STATS_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Reference model: compare state, then advance it with this cycle's inputs.
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      m_ovf = 1'b0; m_hit = '0; m_miss = '0; m_drop = '0;
    end else begin
      logic pop, full;
      ent_t e;
      chk("level", 32'(fifo_level_o), 32'(q.size()));
      chk("valid", 32'(res_valid_o), 32'(q.size() != 0));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("hit_cnt", 32'(hit_cnt_o), 32'(exp_cnt(m_hit)));
      chk("miss_cnt", 32'(miss_cnt_o), 32'(exp_cnt(m_miss)));
      chk("drop_cnt", 32'(drop_cnt_o), 32'(exp_cnt(m_drop)));
      full = (q.size() == FIFO_DEPTH);
      pop  = (q.size() != 0) && res_ready_i;
      if (pop) begin
        e = q.pop_front();
        chk("head_match", 32'(res_match_o), 32'(e.m));
        chk("head_addr", 32'(res_addr_o), 32'(e.a));
        chk("head_data", 32'(res_data_o), 32'(e.d));
      end
      if (lookup_done_i) begin
        if (!full || pop) begin
          q.push_back('{m: lookup_match_i, a: lookup_match_i ? lookup_addr_i : '0, d: lookup_data_i});
          if (lookup_match_i) m_hit = sat_inc(m_hit);
          else                m_miss = sat_inc(m_miss);
        end else begin
          m_ovf = 1'b1;
          m_drop = sat_inc(m_drop);
        end
      end
      if (clr_i) begin
        m_ovf = 1'b0; m_hit = '0; m_miss = '0; m_drop = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic push(input logic m, input logic [A_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d);
    lookup_done_i = 1'b1; lookup_match_i = m; lookup_addr_i = a; lookup_data_i = d;
    tick();
    lookup_done_i = 1'b0;
    lookup_match_i = 1'($urandom); lookup_addr_i = A_WIDTH'($urandom); lookup_data_i = D_WIDTH'($urandom);
  endtask

  task automatic pop_n(input int n);
    res_ready_i = 1'b1;
    repeat (n) tick();
    res_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_valid", 32'(res_valid_o), 32'd0);
      chk("rst_level", 32'(fifo_level_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      lookup_addr_i = A_WIDTH'($urandom); lookup_data_i = D_WIDTH'($urandom);
      tick();
    end

    push(1'b1, 6'h2D, 16'hBEEF);
    chk("hit_valid", 32'(res_valid_o), 32'd1);
    chk("hit_match", 32'(res_match_o), 32'd1);
    chk("hit_addr", 32'(res_addr_o), 32'h2D);
    chk("hit_data", 32'(res_data_o), 32'hBEEF);
    chk("hit_level", 32'(fifo_level_o), 32'd1);
    pop_n(1);

    push(1'b0, 6'h15, 16'h1234);
    chk("miss_match", 32'(res_match_o), 32'd0);
    chk("miss_addr", 32'(res_addr_o), 32'd0);
    chk("miss_data", 32'(res_data_o), 32'h1234);
    pop_n(2);
    chk("empty_pop_level", 32'(fifo_level_o), 32'd0);

    for (int i = 0; i < 10; i++) push(1'(i), A_WIDTH'(i + 1), D_WIDTH'(16'h100 + i));
    chk("ovf_level", 32'(fifo_level_o), 32'd8);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_drops", 32'(drop_cnt_o), 32'(exp_cnt(16'd2)));
    chk("ovf_head", 32'(res_data_o), 32'h100);

    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("clr_ovf", 32'(overflow_o), 32'd0);
    chk("clr_hits", 32'(hit_cnt_o), 32'd0);
    chk("clr_drops", 32'(drop_cnt_o), 32'd0);
    chk("clr_level", 32'(fifo_level_o), 32'd8);
    pop_n(8);

    for (int i = 0; i < 8; i++) push(1'b1, A_WIDTH'(i), D_WIDTH'(16'h200 + i));
    res_ready_i = 1'b1; lookup_done_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      lookup_match_i = 1'(i >> 1); lookup_addr_i = A_WIDTH'(i + 7); lookup_data_i = D_WIDTH'(16'h300 + i);
      tick();
      chk("stream_level", 32'(fifo_level_o), 32'd8);
    end
    res_ready_i = 1'b0; lookup_done_i = 1'b0;
    chk("stream_ovf", 32'(overflow_o), 32'd0);
    chk("stream_head", 32'(res_data_o), 32'h30C);

    // Full FIFO, drop and clear in the same cycle: clear takes priority.
    lookup_done_i = 1'b1; clr_i = 1'b1; tick(); lookup_done_i = 1'b0; clr_i = 1'b0;
    chk("clrdrop_ovf", 32'(overflow_o), 32'd0);
    chk("clrdrop_cnt", 32'(drop_cnt_o), 32'd0);

    pop_n(3);
    chk("pre_rst_level", 32'(fifo_level_o), 32'd5);
    push(1'b1, 6'h3F, 16'hAAAA);
    push(1'b0, 6'h01, 16'h5555);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(res_valid_o), 32'd0);
    chk("arst_level", 32'(fifo_level_o), 32'd0);
    chk("arst_ovf", 32'(overflow_o), 32'd0);
    tick(); tick();
    rst_i = 1'b0;

    for (int i = 0; i < 400; i++) begin
      lookup_done_i = ($urandom_range(0, 3) != 0);
      lookup_match_i = 1'($urandom); lookup_addr_i = A_WIDTH'($urandom); lookup_data_i = D_WIDTH'($urandom);
      res_ready_i = ($urandom_range(0, 2) == 0);
      clr_i = ($urandom_range(0, 40) == 0);
      tick();
    end
    lookup_done_i = 1'b0; clr_i = 1'b0;
    pop_n(FIFO_DEPTH + 1);
    chk("final_level", 32'(fifo_level_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
